// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package imem_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam logic [31:0] NOP           = 32'h00000013;
  localparam logic [31:0] RESP_ERR_INST = 32'h00000000;

endpackage

// File: rtl/imem_ram.sv
// Program store: synchronous write, registered read; a same-edge write/read
// to one index returns the word held before the write.
module imem_ram #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned IdxW  = $clog2(Depth)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_en,
  input  logic [IdxW-1:0] rd_idx,
  output logic [31:0]     rd_data,
  input  logic            wr_en,
  input  logic [IdxW-1:0] wr_idx,
  input  logic [31:0]     wr_data
);

  logic [31:0] mem_q [Depth];
  logic [31:0] rd_data_d, rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/inst_mem_resp.sv
// Instruction-fetch responder: accepts a pc, waits LATENCY cycles, then
// returns the addressed word (or a fault) until the core takes it.
module inst_mem_resp
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h80000000,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned IDX_W     = $clog2(DEPTH),
  parameter int unsigned LATENCY   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_inst,
  output logic             resp_err,
  input  logic             ld_we,
  input  logic [IDX_W-1:0] ld_idx,
  input  logic [31:0]      ld_data
);

  localparam logic [3:0] CntInit = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_e      state_d, state_q;
  logic [3:0]  cnt_d, cnt_q;
  logic [31:0] addr_d, addr_q;
  logic        err_d, err_q;

  logic [31:0]      fetch_addr, off;
  logic [IDX_W-1:0] fetch_idx;
  logic             fetch_err, enter_resp, rd_en;
  logic [31:0]      ram_rd_data;
  logic             unused_off;

  // With zero latency the RESP entry coincides with accept, before addr_q is loaded.
  assign fetch_addr = (state_q == StIdle) ? req_addr : addr_q;
  assign off        = fetch_addr - BASE_ADDR;
  assign fetch_idx  = off[IDX_W+1:2];
  assign fetch_err  = (fetch_addr[1:0] != 2'b00) || (fetch_addr < BASE_ADDR) ||
                      ((off >> 2) >= 32'(DEPTH));
  assign unused_off = ^off[1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d = req_addr;
          if (LATENCY == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    rd_en = enter_resp && !fetch_err;
    if (enter_resp) begin
      err_d = fetch_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  imem_ram #(
    .Depth (DEPTH),
    .IdxW  (IDX_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en),
    .rd_idx  (fetch_idx),
    .rd_data (ram_rd_data),
    .wr_en   (ld_we),
    .wr_idx  (ld_idx),
    .wr_data (ld_data)
  );

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_err   = err_q;
  // A faulted fetch never reads, so the stale read register is masked.
  assign resp_inst  = err_q ? RESP_ERR_INST : ram_rd_data;

endmodule

// File: tb/tb_inst_mem_resp.sv
// Directed bench for inst_mem_resp at LATENCY 0, 2 and 3 (instances 0, 1, 2).
module tb_inst_mem_resp;
  import imem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid  [3];
  logic        req_ready  [3];
  logic [31:0] req_addr   [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_inst  [3];
  logic        resp_err   [3];
  logic        ld_we      [3];
  logic [9:0]  ld_idx     [3];
  logic [31:0] ld_data    [3];

  inst_mem_resp #(.LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_inst(resp_inst[0]), .resp_err(resp_err[0]), .ld_we(ld_we[0]),
    .ld_idx(ld_idx[0]), .ld_data(ld_data[0])
  );
  inst_mem_resp #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_inst(resp_inst[1]), .resp_err(resp_err[1]), .ld_we(ld_we[1]),
    .ld_idx(ld_idx[1]), .ld_data(ld_data[1])
  );
  inst_mem_resp #(.LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_addr(req_addr[2]), .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_inst(resp_inst[2]), .resp_err(resp_err[2]), .ld_we(ld_we[2]),
    .ld_idx(ld_idx[2]), .ld_data(ld_data[2])
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          k;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        err;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  task automatic load_all(input logic [9:0] idx, input logic [31:0] data);
    for (int k = 0; k < 3; k++) begin
      ld_we[k] = 1'b1; ld_idx[k] = idx; ld_data[k] = data;
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) ld_we[k] = 1'b0;
  endtask

  // Called at a negedge with instance k idle; returns at a negedge, idle again.
  task automatic fetch(input int k, input logic [31:0] addr, input logic [31:0] exp_inst,
                       input logic exp_err);
    int n;
    req_valid[k] = 1'b1; req_addr[k] = addr; resp_ready[k] = 1'b1;
    check("req_ready_pre", 32'(req_ready[k]), 32'd1);
    @(negedge clk);
    req_valid[k] = 1'b0;
    req_addr[k]  = 32'hFFFF_FFFF;
    n = 1;
    while (!resp_valid[k] && n < 20) begin
      check("req_ready_busy", 32'(req_ready[k]), 32'd0);
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(lat_of(k) + 1));
    check("inst", resp_inst[k], exp_inst);
    check("err", 32'(resp_err[k]), 32'(exp_err));
    check("req_ready_resp", 32'(req_ready[k]), 32'd0);
    @(negedge clk);
    check("valid_drop", 32'(resp_valid[k]), 32'd0);
    check("ready_back", 32'(req_ready[k]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; req_addr[k] = '0; resp_ready[k] = 1'b0;
      ld_we[k] = 1'b0; ld_idx[k] = '0; ld_data[k] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 3; k++) begin
      check("rst_req_ready", 32'(req_ready[k]), 32'd1);
      check("rst_resp_valid", 32'(resp_valid[k]), 32'd0);
      check("rst_resp_inst", resp_inst[k], 32'd0);
      check("rst_resp_err", 32'(resp_err[k]), 32'd0);
    end

    load_all(10'd0, 32'h00500093);
    load_all(10'd1, 32'h00100113);
    load_all(10'd2, 32'h11111111);
    load_all(10'd3, 32'h33333333);
    load_all(10'd4, NOP);
    load_all(10'd1023, 32'hDEADBEEF);

    vecs[0] = '{1, 32'h80000000, 32'h00500093, 1'b0};
    vecs[1] = '{0, 32'h80000000, 32'h00500093, 1'b0};
    vecs[2] = '{0, 32'h80000004, 32'h00100113, 1'b0};
    vecs[3] = '{0, 32'h80000002, 32'h00000000, 1'b1};
    vecs[4] = '{0, 32'h7FFFFFFC, 32'h00000000, 1'b1};
    vecs[5] = '{2, 32'h80001000, 32'h00000000, 1'b1};
    vecs[6] = '{2, 32'h80000FFC, 32'hDEADBEEF, 1'b0};
    vecs[7] = '{1, 32'h80000010, NOP,          1'b0};
    for (int i = 0; i < 8; i++) begin
      fetch(vecs[i].k, vecs[i].addr, vecs[i].inst, vecs[i].err);
    end

    // Back-to-back at LATENCY 0: req_valid held high across both fetches.
    req_valid[0] = 1'b1; req_addr[0] = 32'h80000000; resp_ready[0] = 1'b1;
    @(negedge clk);
    check("b2b_valid1", 32'(resp_valid[0]), 32'd1);
    check("b2b_inst1", resp_inst[0], 32'h00500093);
    check("b2b_ready1", 32'(req_ready[0]), 32'd0);
    req_addr[0] = 32'h80000004;
    @(negedge clk);
    check("b2b_gap_valid", 32'(resp_valid[0]), 32'd0);
    check("b2b_gap_ready", 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("b2b_valid2", 32'(resp_valid[0]), 32'd1);
    check("b2b_inst2", resp_inst[0], 32'h00100113);
    @(negedge clk);
    check("b2b_end", 32'(resp_valid[0]), 32'd0);

    // Back-pressure: five cycles with resp_ready low.
    req_valid[1] = 1'b1; req_addr[1] = 32'h80000004; resp_ready[1] = 1'b0;
    @(negedge clk);
    req_valid[1] = 1'b0;
    n = 0;
    while (!resp_valid[1] && n < 20) begin @(negedge clk); n++; end
    check("bp_arrive", 32'(resp_valid[1]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(resp_valid[1]), 32'd1);
      check("bp_inst", resp_inst[1], 32'h00100113);
      check("bp_err", 32'(resp_err[1]), 32'd0);
      @(negedge clk);
    end
    resp_ready[1] = 1'b1;
    check("bp_last_valid", 32'(resp_valid[1]), 32'd1);
    @(negedge clk);
    check("bp_done_valid", 32'(resp_valid[1]), 32'd0);
    check("bp_done_ready", 32'(req_ready[1]), 32'd1);

    // Load hits the pending index on the RESP-entry edge: old word returned.
    req_valid[0] = 1'b1; req_addr[0] = 32'h80000008;
    ld_we[0] = 1'b1; ld_idx[0] = 10'd2; ld_data[0] = 32'h22222222;
    @(negedge clk);
    req_valid[0] = 1'b0; ld_we[0] = 1'b0;
    check("coll_valid", 32'(resp_valid[0]), 32'd1);
    check("coll_old", resp_inst[0], 32'h11111111);
    @(negedge clk);
    fetch(0, 32'h80000008, 32'h22222222, 1'b0);

    // Load to the pending index during WAIT: new word returned.
    req_valid[2] = 1'b1; req_addr[2] = 32'h8000000C; resp_ready[2] = 1'b1;
    @(negedge clk);
    req_valid[2] = 1'b0;
    ld_we[2] = 1'b1; ld_idx[2] = 10'd3; ld_data[2] = 32'h44444444;
    @(negedge clk);
    ld_we[2] = 1'b0;
    n = 0;
    while (!resp_valid[2] && n < 20) begin @(negedge clk); n++; end
    check("wait_wr_valid", 32'(resp_valid[2]), 32'd1);
    check("wait_wr_new", resp_inst[2], 32'h44444444);
    @(negedge clk);

    // Reset during WAIT drops the fetch; memory survives.
    req_valid[1] = 1'b1; req_addr[1] = 32'h80000000; resp_ready[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstw_ready", 32'(req_ready[1]), 32'd1);
    check("rstw_valid", 32'(resp_valid[1]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstw_no_resp", 32'(resp_valid[1]), 32'd0);
    end
    fetch(1, 32'h80000000, 32'h00500093, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
